ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 18 +
 rtl/ex_muldiv_div_step.sv | 26 ++
 rtl/ex_muldiv.sv | 160 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: op encodings
// and FSM state encodings.
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CALC   = 2'b01,
    S_FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/ex_muldiv_div_step.sv
// One radix-2 restoring divide step on unsigned magnitudes: shift in the
// next dividend bit, subtract the divisor when it fits, record the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  // The true difference is below the divisor, so WIDTH bits hold it exactly.
  always_comb begin
    w_shifted = {i_rem, i_quo[WIDTH-1]};
    w_fits    = (w_shifted >= {1'b0, i_divisor});
    w_diff    = w_shifted[WIDTH-1:0] - i_divisor;
    o_rem     = w_fits ? w_diff : w_shifted[WIDTH-1:0];
    o_quo     = {i_quo[WIDTH-2:0], w_fits};
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MIPS-style HI/LO multiply/divide unit: fixed WIDTH+2 cycle
// latency, magnitude datapath with sign fix-up on completion.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic [WIDTH-1:0] opnd_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e             r_state, w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  op_e                r_op;
  logic [WIDTH-1:0]   r_hiPart, r_loPart, r_mcand, r_origA;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_negRes, r_negRem, r_divZero;

  logic               w_accept, w_isSigned, w_signA, w_signB, w_latchedDiv;
  logic [WIDTH-1:0]   w_magA, w_magB;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH-1:0]   w_divRem, w_divQuo;
  logic [2*WIDTH-1:0] w_prod, w_prodFix;
  logic [WIDTH-1:0]   w_resHi, w_resLo;

  assign w_isSigned   = (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
  assign w_signA      = w_isSigned && opnd_a[WIDTH-1];
  assign w_signB      = w_isSigned && opnd_b[WIDTH-1];
  assign w_magA       = w_signA ? -opnd_a : opnd_a;
  assign w_magB       = w_signB ? -opnd_b : opnd_b;
  assign w_latchedDiv = (r_op == OP_DIV) || (r_op == OP_DIVU);

  // Shift-add multiply: {r_hiPart, r_loPart} is the product register with
  // the multiplier consumed from its low end.
  assign w_mulSum = {1'b0, r_hiPart} + (r_loPart[0] ? {1'b0, r_mcand} : '0);

  div_step #(.WIDTH(WIDTH)) u_divStep (
    .i_rem     (r_hiPart),
    .i_quo     (r_loPart),
    .i_divisor (r_mcand),
    .o_rem     (w_divRem),
    .o_quo     (w_divQuo)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    stall_req   = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept  = start && !flush;
        stall_req = w_accept;
        if (w_accept) w_nextState = S_CALC;
      end
      S_CALC: begin
        stall_req = !flush;
        if (flush)                              w_nextState = S_IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))    w_nextState = S_FINISH;
      end
      S_FINISH: begin
        done        = !flush;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_op      <= OP_MULT;
      r_hiPart  <= '0;
      r_loPart  <= '0;
      r_mcand   <= '0;
      r_origA   <= '0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_op      <= op_e'(op);
      r_hiPart  <= '0;
      r_loPart  <= op[1] ? w_magA : w_magB;
      r_mcand   <= op[1] ? w_magB : w_magA;
      r_origA   <= opnd_a;
      r_negRes  <= w_signA ^ w_signB;
      r_negRem  <= w_signA;
      r_divZero <= op[1] && (opnd_b == '0);
    end else if (r_state == S_CALC && !flush) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_latchedDiv) begin
        r_hiPart <= w_divRem;
        r_loPart <= w_divQuo;
      end else begin
        r_hiPart <= w_mulSum[WIDTH:1];
        r_loPart <= {w_mulSum[0], r_loPart[WIDTH-1:1]};
      end
    end
  end

  // Sign fix-up of the magnitude result, plus the divide-by-zero override.
  assign w_prod    = {r_hiPart, r_loPart};
  assign w_prodFix = r_negRes ? -w_prod : w_prod;

  always_comb begin
    w_resHi = w_prodFix[2*WIDTH-1:WIDTH];
    w_resLo = w_prodFix[WIDTH-1:0];
    if (w_latchedDiv) begin
      if (r_divZero) begin
        w_resHi = r_origA;
        w_resLo = '1;
      end else begin
        w_resHi = r_negRem ? -r_hiPart : r_hiPart;
        w_resLo = r_negRes ? -r_loPart : r_loPart;
      end
    end
  end

  assign res_hi = done ? w_resHi : '0;
  assign res_lo = done ? w_resLo : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (done) begin
      r_hi <= w_resHi;
      r_lo <= w_resLo;
    end else if (r_state == S_IDLE) begin
      if (hi_we) r_hi <= hi_wdata;
      if (lo_we) r_lo <= lo_wdata;
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, multi-cycle
// corner sequences and randomized operations against an arithmetic model.
module tb_ex_muldiv;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst, start, flush, hi_we, lo_we;
  logic [1:0]       op;
  logic [WIDTH-1:0] opnd_a, opnd_b, hi_wdata, lo_wdata;
  logic             stall_req, done;
  logic [WIDTH-1:0] res_hi, res_lo, hi_o, lo_o;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] mHi, mLo;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] expHi;
    logic [WIDTH-1:0] expLo;
  } vec_t;

  vec_t vecs[12];

  ex_muldiv #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .opnd_a    (opnd_a),
    .opnd_b    (opnd_b),
    .flush     (flush),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .hi_wdata  (hi_wdata),
    .lo_wdata  (lo_wdata),
    .stall_req (stall_req),
    .done      (done),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  // Arithmetic reference for HI/LO, straight from the ISA rules.
  function automatic void model(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b,
                                output logic [WIDTH-1:0] hi, output logic [WIDTH-1:0] lo);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = int'(a);
    sb = int'(b);
    hi = '0;
    lo = '0;
    case (o)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        hi = sp[63:32];
        lo = sp[31:0];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      2'b10: begin
        if (b == 0) begin
          hi = a; lo = '1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = '0; lo = a;
        end else begin
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end
      end
      default: begin
        if (b == 0) begin
          hi = a; lo = '1;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs at the falling edge and settles before sampling.
  task automatic applyStimulus(input logic r, input logic s, input logic [1:0] o,
                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic fl, input logic hwe, input logic lwe,
                               input logic [WIDTH-1:0] hwd, input logic [WIDTH-1:0] lwd);
    @(negedge clk);
    rst = r; start = s; op = o; opnd_a = a; opnd_b = b; flush = fl;
    hi_we = hwe; lo_we = lwe; hi_wdata = hwd; lo_wdata = lwd;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Runs one operation from IDLE; noise drives ignored start/MTHI/MTLO traffic while busy.
  task automatic runOp(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] eHi, input logic [WIDTH-1:0] eLo, input bit noise);
    int doneCyc;
    bit stallOk;
    applyStimulus(1'b0, 1'b1, o, a, b, 1'b0, 1'b0, 1'b0, '0, '0);
    stallOk = (stall_req === 1'b1) && (done === 1'b0);
    doneCyc = -1;
    for (int c = 1; c <= WIDTH + 4 && doneCyc < 0; c++) begin
      if (noise)
        applyStimulus(1'b0, 1'($urandom), 2'($urandom), $urandom, $urandom, 1'b0,
                      1'($urandom), 1'($urandom), $urandom, $urandom);
      else
        idle();
      if (done === 1'b1) begin
        doneCyc = c;
        checkOutput("stall_in_finish", 64'(stall_req), 64'(0));
        checkOutput("res_hi", 64'(res_hi), 64'(eHi));
        checkOutput("res_lo", 64'(res_lo), 64'(eLo));
        checkOutput("hi_before_write", 64'(hi_o), 64'(mHi));
        checkOutput("lo_before_write", 64'(lo_o), 64'(mLo));
      end else if (stall_req !== 1'b1) begin
        stallOk = 1'b0;
      end
    end
    checkOutput("latency", 64'(doneCyc), 64'(WIDTH + 1));
    checkOutput("stall_while_busy", 64'(stallOk), 64'(1));
    idle();
    checkOutput("hi_o_after", 64'(hi_o), 64'(eHi));
    checkOutput("lo_o_after", 64'(lo_o), 64'(eLo));
    mHi = eHi;
    mLo = eLo;
  endtask

  initial begin
    bit               sawDone;
    logic [1:0]       rOp;
    logic [WIDTH-1:0] rA, rB, eHi, eLo;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[5]  = '{2'b11, 32'h0000_0009, 32'h0000_0004, 32'h0000_0001, 32'h0000_0002};
    vecs[6]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8]  = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[9]  = '{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
    vecs[10] = '{2'b10, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
    vecs[11] = '{2'b11, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000};

    // Reset wins over start and MTHI/MTLO in the same cycle.
    applyStimulus(1'b1, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b1, 2'b01, 32'd3, 32'd4, 1'b0, 1'b1, 1'b1, 32'hFFFF, 32'hEEEE);
    idle();
    checkOutput("reset_stall", 64'(stall_req), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_hi", 64'(hi_o), 64'(0));
    checkOutput("reset_lo", 64'(lo_o), 64'(0));
    checkOutput("reset_res_hi", 64'(res_hi), 64'(0));
    checkOutput("reset_res_lo", 64'(res_lo), 64'(0));
    mHi = '0;
    mLo = '0;

    foreach (vecs[i]) runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, 1'b0);

    // MTHI/MTLO together with an accepted start: visible next cycle, then overwritten.
    applyStimulus(1'b0, 1'b1, 2'b01, 32'd6, 32'd7, 1'b0, 1'b1, 1'b1, 32'hAAAA, 32'hBBBB);
    idle();
    checkOutput("mt_with_start_hi", 64'(hi_o), 64'(32'hAAAA));
    checkOutput("mt_with_start_lo", 64'(lo_o), 64'(32'hBBBB));
    for (int c = 2; c <= WIDTH; c++) idle();
    idle();
    checkOutput("mt_start_done", 64'(done), 64'(1));
    checkOutput("mt_start_res_lo", 64'(res_lo), 64'(42));
    idle();
    checkOutput("mt_start_final_hi", 64'(hi_o), 64'(0));
    checkOutput("mt_start_final_lo", 64'(lo_o), 64'(42));
    mHi = '0;
    mLo = 32'd42;

    // MTHI in IDLE, then a DIVU flushed mid-calculation; the next start is accepted.
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b1, 1'b0, 32'h1234, '0);
    idle();
    checkOutput("mthi", 64'(hi_o), 64'(32'h1234));
    mHi = 32'h1234;
    applyStimulus(1'b0, 1'b1, 2'b11, 32'd9, 32'd4, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int c = 1; c <= 9; c++) idle();
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
    checkOutput("flush_calc_stall", 64'(stall_req), 64'(0));
    checkOutput("flush_calc_done", 64'(done), 64'(0));
    runOp(2'b11, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);

    // Flush during FINISH suppresses done and the HI/LO write.
    applyStimulus(1'b0, 1'b1, 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int c = 1; c <= WIDTH; c++) idle();
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
    checkOutput("flush_finish_done", 64'(done), 64'(0));
    checkOutput("flush_finish_stall", 64'(stall_req), 64'(0));
    idle();
    checkOutput("flush_finish_hi", 64'(hi_o), 64'(mHi));
    checkOutput("flush_finish_lo", 64'(lo_o), 64'(mLo));

    // Flush in IDLE blocks a start.
    applyStimulus(1'b0, 1'b1, 2'b00, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0, '0, '0);
    checkOutput("flush_idle_stall", 64'(stall_req), 64'(0));
    sawDone = 1'b0;
    for (int c = 1; c <= WIDTH + 3; c++) begin
      idle();
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("flush_idle_no_done", 64'(sawDone), 64'(0));

    // Randomized operations, with ignored start and MTHI/MTLO traffic while busy.
    for (int n = 0; n < 40; n++) begin
      rOp = 2'($urandom);
      rA  = $urandom;
      rB  = $urandom;
      case ($urandom_range(0, 7))
        0: rB = '0;
        1: rB = 32'($urandom_range(1, 15));
        2: begin rA = 32'h8000_0000; rB = 32'hFFFF_FFFF; end
        3: rA = 32'($urandom_range(0, 255));
        default: ;
      endcase
      model(rOp, rA, rB, eHi, eLo);
      runOp(rOp, rA, rB, eHi, eLo, 1'b1);
    end

    // Reset in cycle 5 of a MULT: back to IDLE with HI/LO cleared and no done.
    applyStimulus(1'b0, 1'b1, 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int c = 1; c <= 4; c++) idle();
    applyStimulus(1'b1, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    idle();
    checkOutput("rst_mid_stall", 64'(stall_req), 64'(0));
    checkOutput("rst_mid_done", 64'(done), 64'(0));
    checkOutput("rst_mid_hi", 64'(hi_o), 64'(0));
    checkOutput("rst_mid_lo", 64'(lo_o), 64'(0));
    sawDone = 1'b0;
    for (int c = 0; c < WIDTH + 4; c++) begin
      idle();
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("rst_mid_no_done", 64'(sawDone), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
